// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and divisor helper.
package uart_pkg;

  localparam int BAUD_SLOW  = 9600;
  localparam int BAUD_FAST  = 115200;
  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per bit, integer-truncated.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rdata without a pop.
// Pointers carry one extra bit so full and empty can be told apart.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem[rd_ptr_q[AW-1:0]];

  // Pop only when data exists; a full FIFO still takes a write if a pop frees a slot.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_top.sv
// 8N1 UART with TX/RX FIFOs, per-direction 9600/115200 baud select and a level IRQ.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       UART_EN,
  input  logic [1:0] IRQ_EN,
  input  logic       RXBAUD,
  input  logic       TXBAUD,
  input  logic       WR_TX,
  input  logic       RD_RX,
  input  logic [7:0] WRDATA,
  output logic [7:0] RXDATA,
  output logic       TXD,
  output logic       TX_FLAG,
  output logic       RX_FLAG,
  output logic       UART_IRQ,
  output logic       TXFIFO_EMPTY,
  output logic       RXFIFO_EMPTY
);

  localparam int DIV_SLOW_I = baud_div(CLK_HZ, BAUD_SLOW);
  localparam int DIV_FAST_I = baud_div(CLK_HZ, BAUD_FAST);
  localparam int CNT_W      = $clog2(DIV_SLOW_I + 1);

  localparam logic [CNT_W-1:0] DIV_SLOW = CNT_W'(DIV_SLOW_I);
  localparam logic [CNT_W-1:0] DIV_FAST = CNT_W'(DIV_FAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(FRAME_BITS - 1);

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_fifo_data;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_fifo_data;

  // A full TX FIFO only accepts a write when the engine frees a slot the same cycle.
  assign tx_push = WR_TX & (~tx_full | tx_pop);
  assign rx_pop  = RD_RX;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (WRDATA),
    .rdata (tx_fifo_data),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // ---------------- TX engine ----------------
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - CNT_ONE);

  // TX next state: load a byte at frame start, hold each bit for one divisor period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (UART_EN && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_fifo_data;
          tx_div_d   = TXBAUD ? DIV_FAST : DIV_SLOW;
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == LAST_BIT) tx_state_d = ST_STOP;
          else                      tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (UART_EN && !tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_fifo_data;
            tx_div_d   = TXBAUD ? DIV_FAST : DIV_SLOW;
            tx_state_d = ST_START;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // TX engine registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_SLOW;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Line level follows the state directly, so reset forces it high at once.
  always_comb begin
    case (tx_state_q)
      ST_START: TXD = 1'b0;
      ST_DATA:  TXD = tx_shift_q[0];
      default:  TXD = 1'b1;
    endcase
  end

  assign TX_FLAG = (tx_state_q != ST_IDLE);

  // ---------------- RX engine ----------------
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q;
  logic             rx_line;
  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_flag_q;
  logic             rx_bit_end, rx_half_end;

  assign rx_line     = rx_sync_q[1];
  assign rx_bit_end  = (rx_cnt_q == rx_div_q - CNT_ONE);
  assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - CNT_ONE);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], RXD};
      rx_prev_q <= rx_line;
    end
  end

  // RX next state: validate start at half-bit, then sample data and stop at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (UART_EN && rx_prev_q && !rx_line) begin
          rx_div_d   = RXBAUD ? DIV_FAST : DIV_SLOW;
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_half_end) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // A line back high at mid-start was a glitch, not a frame.
          rx_state_d = rx_line ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = ST_STOP;
          else                      rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          // Framing errors and overruns drop the byte silently.
          rx_push    = rx_line & ~rx_full;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX engine registers and the stored-byte pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_SLOW;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_flag_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_flag_q  <= rx_push;
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_shift_q),
    .rdata (rx_fifo_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  // ---------------- status ----------------
  assign RX_FLAG      = rx_flag_q;
  assign RXDATA       = rx_empty ? 8'h00 : rx_fifo_data;
  assign TXFIFO_EMPTY = tx_empty;
  assign RXFIFO_EMPTY = rx_empty;
  assign UART_IRQ     = (IRQ_EN[0] & ~rx_empty) | (IRQ_EN[1] & tx_empty & ~TX_FLAG);

endmodule

// File: tb/tb_uart_top.sv
// Scenario bench for uart_top with a scaled-down clock so frames stay short.
module tb_uart_top;

  localparam int CLK_HZ = 960000;
  localparam int DEPTH  = 16;
  localparam int DIV_S  = 100;  // 960000 / 9600
  localparam int DIV_F  = 8;    // 960000 / 115200 = 8.33, truncated

  logic       CLK = 1'b0;
  logic       RST, RXD, UART_EN, RXBAUD, TXBAUD, WR_TX, RD_RX;
  logic [1:0] IRQ_EN;
  logic [7:0] WRDATA;
  logic [7:0] RXDATA;
  logic       TXD, TX_FLAG, RX_FLAG, UART_IRQ, TXFIFO_EMPTY, RXFIFO_EMPTY;

  int errors = 0;
  int checks = 0;
  int rx_flag_cnt = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  uart_top #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .UART_EN(UART_EN), .IRQ_EN(IRQ_EN),
    .RXBAUD(RXBAUD), .TXBAUD(TXBAUD), .WR_TX(WR_TX), .RD_RX(RD_RX), .WRDATA(WRDATA),
    .RXDATA(RXDATA), .TXD(TXD), .TX_FLAG(TX_FLAG), .RX_FLAG(RX_FLAG), .UART_IRQ(UART_IRQ),
    .TXFIFO_EMPTY(TXFIFO_EMPTY), .RXFIFO_EMPTY(RXFIFO_EMPTY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (RX_FLAG === 1'b1) rx_flag_cnt++;

  initial begin
    #(10 * 300000);
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Serial frame into RXD at 9600 baud; scoreboard keeps what the FIFO should hold.
  task automatic send_rx_frame(input logic [7:0] b, input logic stop);
    if (stop && rx_exp.size() < DEPTH) rx_exp.push_back(b);
    RXD = 1'b0; tick(DIV_S);
    for (int i = 0; i < 8; i++) begin RXD = b[i]; tick(DIV_S); end
    RXD = stop; tick(DIV_S);
    RXD = 1'b1; tick(4);
    $display("rx frame sent data=%02h stop=%b", b, stop);
  endtask

  // Decode one TX frame at 115200 by mid-bit sampling; TX_FLAG must stay high.
  task automatic tx_decode(output logic [7:0] b, output logic ok, output int gap);
    logic start_v, stop_v, flag_ok;
    gap = 0; b = 8'h00; ok = 1'b0; flag_ok = 1'b1;
    while (TXD !== 1'b0 && gap < 40 * DIV_F) begin tick(1); gap++; end
    if (TXD !== 1'b0) return;
    tick(DIV_F / 2); start_v = TXD; if (TX_FLAG !== 1'b1) flag_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(DIV_F); b[i] = TXD; if (TX_FLAG !== 1'b1) flag_ok = 1'b0;
    end
    tick(DIV_F); stop_v = TXD; if (TX_FLAG !== 1'b1) flag_ok = 1'b0;
    ok = (start_v === 1'b0) && (stop_v === 1'b1) && flag_ok;
    $display("tx frame decoded data=%02h ok=%b gap=%0d", b, ok, gap);
  endtask

  task automatic test_reset();
    RST = 1'b1; RXD = 1'b1; UART_EN = 1'b0; RXBAUD = 1'b0; TXBAUD = 1'b0;
    WR_TX = 1'b0; RD_RX = 1'b0; WRDATA = 8'h00; IRQ_EN = 2'b10;
    tick(3);
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", TXD); end
    checks++; if (TX_FLAG !== 1'b0) begin errors++; $display("FAIL reset_tx_flag: got %b want 0", TX_FLAG); end
    checks++; if (RX_FLAG !== 1'b0) begin errors++; $display("FAIL reset_rx_flag: got %b want 0", RX_FLAG); end
    checks++; if (RXDATA !== 8'h00) begin errors++; $display("FAIL reset_rxdata: got %02h want 00", RXDATA); end
    checks++; if (TXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_txfifo_empty: got %b want 1", TXFIFO_EMPTY); end
    checks++; if (RXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_rxfifo_empty: got %b want 1", RXFIFO_EMPTY); end
    checks++; if (UART_IRQ !== 1'b1) begin errors++; $display("FAIL reset_irq_tx: got %b want 1", UART_IRQ); end
    IRQ_EN = 2'b01; tick(1);
    checks++; if (UART_IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq_rx: got %b want 0", UART_IRQ); end
    RST = 1'b0; tick(2);
    $display("reset test done");
  endtask

  task automatic test_rx_stream();
    int base;
    UART_EN = 1'b1; RXBAUD = 1'b0; IRQ_EN = 2'b01;
    base = rx_flag_cnt;
    send_rx_frame(8'h69, 1'b1);
    send_rx_frame(8'h96, 1'b1);
    send_rx_frame(8'h13, 1'b1);
    send_rx_frame(8'h24, 1'b1);
    send_rx_frame(8'h57, 1'b1);
    checks++; if (rx_flag_cnt - base !== 5) begin errors++; $display("FAIL rx_flag_count: got %0d want 5", rx_flag_cnt - base); end
    checks++; if (RXFIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL rx_not_empty: got %b want 0", RXFIFO_EMPTY); end
    checks++; if (UART_IRQ !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b want 1", UART_IRQ); end
    checks++; if (RXDATA !== rx_exp[0]) begin errors++; $display("FAIL rx_head: got %02h want %02h", RXDATA, rx_exp[0]); end
  endtask

  task automatic test_rx_read();
    for (int i = 0; i < 4; i++) begin
      RD_RX = 1'b1; void'(rx_exp.pop_front()); tick(1);
      RD_RX = 1'b0; tick(1);
      checks++;
      if (RXDATA !== rx_exp[0]) begin errors++; $display("FAIL rx_read_%0d: got %02h want %02h", i, RXDATA, rx_exp[0]); end
      else $display("rx read %0d data=%02h", i, RXDATA);
    end
    RD_RX = 1'b1; if (rx_exp.size() > 0) void'(rx_exp.pop_front()); tick(2);
    RD_RX = 1'b0; tick(1);
    checks++; if (RXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rx_drain_empty: got %b want 1", RXFIFO_EMPTY); end
    checks++; if (RXDATA !== 8'h00) begin errors++; $display("FAIL rx_drain_data: got %02h want 00", RXDATA); end
    checks++; if (UART_IRQ !== 1'b0) begin errors++; $display("FAIL rx_drain_irq: got %b want 0", UART_IRQ); end
  endtask

  task automatic test_tx_back_to_back();
    logic [7:0] b, e; logic ok; int gap;
    TXBAUD = 1'b1; IRQ_EN = 2'b10; UART_EN = 1'b1; tick(1);
    WR_TX = 1'b1; WRDATA = 8'h13; tx_exp.push_back(8'h13); tick(1);
    WRDATA = 8'h24; tx_exp.push_back(8'h24); tick(1);
    WR_TX = 1'b0;
    for (int f = 0; f < 2; f++) begin
      tx_decode(b, ok, gap);
      e = tx_exp.pop_front();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tx_b2b_frame_%0d: got ok=%b want 1", f, ok); end
      checks++; if (b !== e) begin errors++; $display("FAIL tx_b2b_data_%0d: got %02h want %02h", f, b, e); end
      if (f == 1) begin
        checks++; if (gap > DIV_F / 2 + 1) begin errors++; $display("FAIL tx_b2b_gap: got %0d want <=%0d", gap, DIV_F / 2 + 1); end
      end
    end
    tick(DIV_F);
    checks++; if (TX_FLAG !== 1'b0) begin errors++; $display("FAIL tx_done_flag: got %b want 0", TX_FLAG); end
    checks++; if (TXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL tx_done_empty: got %b want 1", TXFIFO_EMPTY); end
    checks++; if (UART_IRQ !== 1'b1) begin errors++; $display("FAIL tx_done_irq: got %b want 1", UART_IRQ); end
  endtask

  task automatic test_rx_errors();
    int base;
    IRQ_EN = 2'b01; RXBAUD = 1'b0;
    base = rx_flag_cnt;
    send_rx_frame(8'h55, 1'b0);
    checks++; if (rx_flag_cnt - base !== 0) begin errors++; $display("FAIL rx_framing_flag: got %0d want 0", rx_flag_cnt - base); end
    checks++; if (RXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rx_framing_empty: got %b want 1", RXFIFO_EMPTY); end
    RXD = 1'b0; tick(20); RXD = 1'b1; tick(3 * DIV_S);
    $display("rx glitch sent width=20");
    checks++; if (rx_flag_cnt - base !== 0) begin errors++; $display("FAIL rx_glitch_flag: got %0d want 0", rx_flag_cnt - base); end
    checks++; if (RXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rx_glitch_empty: got %b want 1", RXFIFO_EMPTY); end
    send_rx_frame(8'hA5, 1'b1);
    checks++; if (rx_flag_cnt - base !== 1) begin errors++; $display("FAIL rx_recover_flag: got %0d want 1", rx_flag_cnt - base); end
    checks++; if (RXDATA !== rx_exp[0]) begin errors++; $display("FAIL rx_recover_data: got %02h want %02h", RXDATA, rx_exp[0]); end
    RD_RX = 1'b1; void'(rx_exp.pop_front()); tick(1); RD_RX = 1'b0; tick(1);
  endtask

  task automatic test_overflow();
    int base; logic [7:0] b, e; logic ok; int gap;
    base = rx_flag_cnt;
    for (int i = 0; i < 17; i++) send_rx_frame(8'h30 + 8'(i), 1'b1);
    checks++; if (rx_flag_cnt - base !== 16) begin errors++; $display("FAIL rx_overrun_flags: got %0d want 16", rx_flag_cnt - base); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (RXDATA !== rx_exp[0]) begin errors++; $display("FAIL rx_overrun_data_%0d: got %02h want %02h", i, RXDATA, rx_exp[0]); end
      RD_RX = 1'b1; void'(rx_exp.pop_front()); tick(1); RD_RX = 1'b0; tick(1);
    end
    checks++; if (RXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rx_overrun_empty: got %b want 1", RXFIFO_EMPTY); end
    UART_EN = 1'b0; TXBAUD = 1'b1; tick(1);
    for (int i = 0; i < 17; i++) begin
      WR_TX = 1'b1; WRDATA = 8'hC0 + 8'(i);
      if (tx_exp.size() < DEPTH) tx_exp.push_back(WRDATA);
      tick(1);
    end
    WR_TX = 1'b0; tick(2);
    checks++; if (TXFIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL tx_disabled_empty: got %b want 0", TXFIFO_EMPTY); end
    checks++; if (TX_FLAG !== 1'b0) begin errors++; $display("FAIL tx_disabled_flag: got %b want 0", TX_FLAG); end
    UART_EN = 1'b1;
    for (int f = 0; f < 16; f++) begin
      tx_decode(b, ok, gap);
      e = tx_exp.pop_front();
      checks++;
      if (ok !== 1'b1 || b !== e) begin errors++; $display("FAIL tx_full_frame_%0d: got %02h ok=%b want %02h ok=1", f, b, ok, e); end
    end
    tick(DIV_F);
    checks++; if (TX_FLAG !== 1'b0) begin errors++; $display("FAIL tx_full_17th_dropped: got flag %b want 0", TX_FLAG); end
    checks++; if (TXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL tx_full_drained: got %b want 1", TXFIFO_EMPTY); end
  endtask

  task automatic test_disable_mid_frame();
    logic [7:0] b, e; logic ok; int gap;
    UART_EN = 1'b1; TXBAUD = 1'b1;
    WR_TX = 1'b1; WRDATA = 8'hA1; tx_exp.push_back(8'hA1); tick(1);
    WRDATA = 8'hB2; tx_exp.push_back(8'hB2); tick(1);
    WR_TX = 1'b0;
    fork
      begin tick(3 * DIV_F); UART_EN = 1'b0; end
    join_none
    tx_decode(b, ok, gap);
    e = tx_exp.pop_front();
    checks++; if (ok !== 1'b1 || b !== e) begin errors++; $display("FAIL tx_disable_finish: got %02h ok=%b want %02h ok=1", b, ok, e); end
    tick(30 * DIV_F);
    checks++; if (TX_FLAG !== 1'b0) begin errors++; $display("FAIL tx_disable_idle: got %b want 0", TX_FLAG); end
    checks++; if (TXFIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL tx_disable_kept: got %b want 0", TXFIFO_EMPTY); end
    UART_EN = 1'b1;
    tx_decode(b, ok, gap);
    e = tx_exp.pop_front();
    checks++; if (ok !== 1'b1 || b !== e) begin errors++; $display("FAIL tx_disable_resume: got %02h ok=%b want %02h ok=1", b, ok, e); end
    tick(DIV_F);
  endtask

  task automatic test_reset_mid_tx();
    RXBAUD = 1'b0; UART_EN = 1'b1; TXBAUD = 1'b1;
    send_rx_frame(8'h77, 1'b1);
    checks++; if (RXFIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL rst_rx_preload: got %b want 0", RXFIFO_EMPTY); end
    WR_TX = 1'b1; WRDATA = 8'h5A; tick(1);
    WRDATA = 8'h3C; tick(1);
    WR_TX = 1'b0; tick(3 * DIV_F);
    checks++; if (TX_FLAG !== 1'b1) begin errors++; $display("FAIL rst_tx_busy: got %b want 1", TX_FLAG); end
    RST = 1'b1; #1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b want 1", TXD); end
    checks++; if (TX_FLAG !== 1'b0) begin errors++; $display("FAIL rst_mid_flag: got %b want 0", TX_FLAG); end
    checks++; if (TXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rst_mid_txfifo: got %b want 1", TXFIFO_EMPTY); end
    checks++; if (RXFIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rst_mid_rxfifo: got %b want 1", RXFIFO_EMPTY); end
    checks++; if (RXDATA !== 8'h00) begin errors++; $display("FAIL rst_mid_rxdata: got %02h want 00", RXDATA); end
    rx_exp.delete(); tx_exp.delete();
    tick(2); RST = 1'b0; tick(12 * DIV_F);
    checks++; if (TX_FLAG !== 1'b0) begin errors++; $display("FAIL rst_no_resume: got %b want 0", TX_FLAG); end
  endtask

  initial begin
    test_reset();
    test_rx_stream();
    test_rx_read();
    test_tx_back_to_back();
    test_rx_errors();
    test_overflow();
    test_disable_mid_frame();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
